// File: rtl/karatsuba_sequencer.sv
// karatsuba_sequencer: steps a Karatsuba multiplier datapath through NUM_STEPS states with start/hold/abort handshake
module karatsuba_sequencer #(
  parameter int NUM_STEPS   = 10,
  parameter int SIGNAL_STEP = 4,
  parameter int STATE_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  input  logic               abort,
  output logic [STATE_W-1:0] state,
  output logic               sinal,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               start_ignored
);
  localparam logic [STATE_W-1:0] LAST   = STATE_W'(NUM_STEPS);
  localparam logic [STATE_W-1:0] DONE_S = STATE_W'(NUM_STEPS + 1);
  localparam logic [STATE_W-1:0] SIG_S  = STATE_W'(SIGNAL_STEP + 1);
  localparam logic [STATE_W-1:0] FIRST  = STATE_W'(1);
  generate
    if (NUM_STEPS < 1 || SIGNAL_STEP < 0 || SIGNAL_STEP >= NUM_STEPS || (2 ** STATE_W) <= NUM_STEPS + 1) begin : g_bad_params
      $error("karatsuba_sequencer: illegal NUM_STEPS/SIGNAL_STEP/STATE_W combination");
    end
  endgenerate
  logic [STATE_W-1:0] state_nx;
  assign busy  = state != '0 && state <= LAST;
  assign done  = state == DONE_S;
  assign sinal = state == SIG_S;
  // Idle, done and any illegal encoding all fall back to the idle decision.
  always_comb begin
    state_nx = start ? FIRST : '0;
    if (busy) state_nx = abort ? '0 : hold ? state : state + FIRST;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= '0;
      aborted       <= 1'b0;
      start_ignored <= 1'b0;
    end else begin
      state         <= state_nx;
      aborted       <= busy & abort;
      start_ignored <= busy & start;
    end
  end
endmodule

// File: tb/tb_karatsuba_sequencer.sv
// tb_karatsuba_sequencer: scoreboard bench comparing default and small configurations against a reference model
module tb_karatsuba_sequencer;
  logic clock = 1'b0;
  logic reset, start, hold, abort;
  logic [3:0] a_state;
  logic a_sinal, a_busy, a_done, a_ab, a_ig;
  logic [2:0] b_state;
  logic b_sinal, b_busy, b_done, b_ab, b_ig;
  int checks = 0;
  int errors = 0;
  typedef struct {int st; bit ab; bit ig;} m_t;
  typedef struct {m_t a; m_t b;} e_t;
  e_t q[$];
  m_t ma, mb;
  always #5 clock = ~clock;
  karatsuba_sequencer dut_a (
    .clock(clock), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .state(a_state), .sinal(a_sinal), .busy(a_busy), .done(a_done),
    .aborted(a_ab), .start_ignored(a_ig)
  );
  karatsuba_sequencer #(.NUM_STEPS(3), .SIGNAL_STEP(0), .STATE_W(3)) dut_b (
    .clock(clock), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .state(b_state), .sinal(b_sinal), .busy(b_busy), .done(b_done),
    .aborted(b_ab), .start_ignored(b_ig)
  );
  function automatic m_t nxt(m_t m, int n, bit s, bit h, bit a);
    m_t r;
    r.ab = 1'b0;
    r.ig = 1'b0;
    if (m.st >= 1 && m.st <= n) begin
      r.ig = s;
      r.ab = a;
      r.st = a ? 0 : h ? m.st : m.st + 1;
    end else r.st = s ? 1 : 0;
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask
  task automatic cmpm(string tag, m_t m, int n, int sg, int st, logic si, logic bu, logic dn, logic ab, logic ig);
    chk({tag, " state"}, st, m.st);
    chk({tag, " sinal"}, 32'(si), 32'(m.st == sg + 1));
    chk({tag, " busy"}, 32'(bu), 32'(m.st >= 1 && m.st <= n));
    chk({tag, " done"}, 32'(dn), 32'(m.st == n + 1));
    chk({tag, " aborted"}, 32'(ab), 32'(m.ab));
    chk({tag, " start_ignored"}, 32'(ig), 32'(m.ig));
  endtask
  always @(posedge clock) begin
    e_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmpm("def", e.a, 10, 4, int'(a_state), a_sinal, a_busy, a_done, a_ab, a_ig);
      cmpm("small", e.b, 3, 0, int'(b_state), b_sinal, b_busy, b_done, b_ab, b_ig);
    end
  end
  task automatic cyc(bit s, bit h, bit a);
    @(negedge clock);
    start = s;
    hold  = h;
    abort = a;
    ma = nxt(ma, 10, s, h, a);
    mb = nxt(mb, 3, s, h, a);
    q.push_back('{ma, mb});
  endtask
  task automatic idle_check(string tag);
    chk({tag, " def state"}, 32'(a_state), 0);
    chk({tag, " def busy"}, 32'(a_busy), 0);
    chk({tag, " def sinal"}, 32'(a_sinal), 0);
    chk({tag, " def done"}, 32'(a_done), 0);
    chk({tag, " small state"}, 32'(b_state), 0);
    chk({tag, " small busy"}, 32'(b_busy), 0);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    abort = 1'b0;
    ma = '{0, 1'b0, 1'b0};
    mb = '{0, 1'b0, 1'b0};
    #1 idle_check("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (12) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    repeat (3) cyc(0, 1, 0);
    repeat (10) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (12) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (12) cyc(0, 0, 0);
    cyc(1, 0, 1);
    cyc(0, 1, 1);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 idle_check("async reset");
    ma = '{0, 1'b0, 1'b0};
    mb = '{0, 1'b0, 1'b0};
    @(negedge clock);
    reset = 1'b0;
    repeat (3) cyc(0, 0, 0);
    repeat (3000) cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0);
    repeat (3) @(negedge clock);
    chk("scoreboard drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
